fwd_hazard_ctrl: RTL

- Central stall/forward controller for the 5-stage pipeline: D, E, M, W.
- Keeps a shadow pipeline of register-use and result-timing info: destination, source registers, and Tnew (cycles until the result exists).
- Raises D-stage stall and drives the select codes of every forwarding mux: D-stage rs/rt, E-stage rs/rt, M-stage rt.
- Replaces the per-stage combinational decode; one registered view of hazard state for the whole core.

---
 rtl/fwd_hazard_ctrl_pkg.sv | 26 ++
 rtl/fwd_hazard_ctrl_sel_pick.sv | 27 ++
 rtl/fwd_hazard_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared select encodings and operand-use constants for the hazard controller
// and its forwarding-select pickers.
package fwd_hazard_ctrl_pkg;

  localparam int SEL_W = 3;
  typedef logic [SEL_W-1:0] sel_t;

  // D-stage operand mux selects
  localparam sel_t FWD_RF = 3'd0;
  localparam sel_t FWD_E  = 3'd1;
  localparam sel_t FWD_M  = 3'd2;
  localparam sel_t FWD_W  = 3'd3;

  // E-stage operand mux selects
  localparam sel_t FWDE_REG = 3'd0;
  localparam sel_t FWDE_M   = 3'd1;
  localparam sel_t FWDE_W   = 3'd2;

  // M-stage store-data mux selects
  localparam sel_t FWDM_REG = 3'd0;
  localparam sel_t FWDM_W   = 3'd1;

  // Tuse value meaning "operand not read by this instruction"
  localparam int TUSE_NONE = 3;

endpackage

// File: rtl/fwd_hazard_ctrl_sel_pick.sv
// Priority forwarding-select picker: index 0 is the nearest producer and wins.
// A candidate qualifies when its dst is non-zero, matches addr, and its result exists.
module fwd_sel_pick
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int RA_W = 5,
  parameter int T_W  = 2,
  parameter int N    = 3
) (
  input  logic [RA_W-1:0]         addr,
  input  logic [N-1:0][RA_W-1:0]  dst,
  input  logic [N-1:0][T_W-1:0]   tnew,
  input  sel_t [N-1:0]            code,
  output sel_t                    sel
);

  // Every stage's "no forward" encoding is zero.
  always_comb begin
    sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if ((addr != '0) && (dst[i] == addr) && (tnew[i] == '0)) begin
        sel = code[i];
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Central stall/forward controller: a registered shadow of E/M/W register use
// and result timing drives the D stall and every forwarding mux select.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int RA_W = 5,
  parameter int T_W  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            d_valid,
  input  logic [RA_W-1:0] d_rs,
  input  logic [RA_W-1:0] d_rt,
  input  logic [T_W-1:0]  d_tuse_rs,
  input  logic [T_W-1:0]  d_tuse_rt,
  input  logic [RA_W-1:0] d_dst,
  input  logic [T_W-1:0]  d_tnew,
  input  logic            d_is_md,
  input  logic            e_md_start,
  input  logic            md_busy,
  output logic            stall,
  output logic [2:0]      frs_d,
  output logic [2:0]      frt_d,
  output logic [2:0]      frs_e,
  output logic [2:0]      frt_e,
  output logic [2:0]      frt_m
);

  localparam logic [T_W-1:0] TUSE_N = T_W'(TUSE_NONE);
  localparam logic [T_W-1:0] W_TNEW = '0;

  logic [RA_W-1:0] e_rs, e_rt, e_dst;
  logic [T_W-1:0]  e_tnew;
  logic [RA_W-1:0] m_rt, m_dst;
  logic [T_W-1:0]  m_tnew;
  logic [RA_W-1:0] w_dst;

  logic rs_haz, rt_haz, md_haz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_rs   <= '0;
      e_rt   <= '0;
      e_dst  <= '0;
      e_tnew <= '0;
      m_rt   <= '0;
      m_dst  <= '0;
      m_tnew <= '0;
      w_dst  <= '0;
    end else begin
      if (stall || !d_valid) begin
        e_rs   <= '0;
        e_rt   <= '0;
        e_dst  <= '0;
        e_tnew <= '0;
      end else begin
        e_rs   <= d_rs;
        e_rt   <= d_rt;
        e_dst  <= d_dst;
        e_tnew <= d_tnew;
      end
      m_rt   <= e_rt;
      m_dst  <= e_dst;
      m_tnew <= (e_tnew == '0) ? '0 : e_tnew - T_W'(1);
      w_dst  <= m_dst;
    end
  end

  // W results always exist, so only E and M producers can stall D.
  assign rs_haz = (d_rs != '0) && (d_tuse_rs != TUSE_N) &&
                  (((d_rs == e_dst) && (e_tnew > d_tuse_rs)) ||
                   ((d_rs == m_dst) && (m_tnew > d_tuse_rs)));
  assign rt_haz = (d_rt != '0) && (d_tuse_rt != TUSE_N) &&
                  (((d_rt == e_dst) && (e_tnew > d_tuse_rt)) ||
                   ((d_rt == m_dst) && (m_tnew > d_tuse_rt)));
  assign md_haz = d_is_md && (md_busy || e_md_start);
  assign stall  = d_valid && (rs_haz || rt_haz || md_haz);

  fwd_sel_pick #(.RA_W(RA_W), .T_W(T_W), .N(3)) u_pick_rs_d (
    .addr (d_rs),
    .dst  ({w_dst, m_dst, e_dst}),
    .tnew ({W_TNEW, m_tnew, e_tnew}),
    .code ({FWD_W, FWD_M, FWD_E}),
    .sel  (frs_d)
  );

  fwd_sel_pick #(.RA_W(RA_W), .T_W(T_W), .N(3)) u_pick_rt_d (
    .addr (d_rt),
    .dst  ({w_dst, m_dst, e_dst}),
    .tnew ({W_TNEW, m_tnew, e_tnew}),
    .code ({FWD_W, FWD_M, FWD_E}),
    .sel  (frt_d)
  );

  fwd_sel_pick #(.RA_W(RA_W), .T_W(T_W), .N(2)) u_pick_rs_e (
    .addr (e_rs),
    .dst  ({w_dst, m_dst}),
    .tnew ({W_TNEW, m_tnew}),
    .code ({FWDE_W, FWDE_M}),
    .sel  (frs_e)
  );

  fwd_sel_pick #(.RA_W(RA_W), .T_W(T_W), .N(2)) u_pick_rt_e (
    .addr (e_rt),
    .dst  ({w_dst, m_dst}),
    .tnew ({W_TNEW, m_tnew}),
    .code ({FWDE_W, FWDE_M}),
    .sel  (frt_e)
  );

  fwd_sel_pick #(.RA_W(RA_W), .T_W(T_W), .N(1)) u_pick_rt_m (
    .addr (m_rt),
    .dst  (w_dst),
    .tnew (W_TNEW),
    .code (FWDM_W),
    .sel  (frt_m)
  );

endmodule
